pipe_shifter: RTL and testbench

PIPE_SHIFTER -- requirements
Module: pipe_shifter

---
 rtl/shf_pkg.sv | 23 ++
 rtl/shf_bytestage.sv | 35 +++
 rtl/pipe_shifter.sv | 123 ++++++++++++
 tb/tb_pipe_shifter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/shf_pkg.sv
// shf_pkg: shared op/size encodings and size helpers for pipe_shifter.
package shf_pkg;
  typedef enum logic [2:0] {
    SHF_OP_SHL = 3'd0,
    SHF_OP_SHR = 3'd1,
    SHF_OP_SAR = 3'd2,
    SHF_OP_ROL = 3'd3,
    SHF_OP_ROR = 3'd4
  } shf_op_e;
  typedef enum logic [1:0] {
    SHF_SZ_8  = 2'd0,
    SHF_SZ_16 = 2'd1,
    SHF_SZ_32 = 2'd2,
    SHF_SZ_64 = 2'd3
  } shf_sz_e;
  localparam int SHF_MAXW = 128;
  function automatic logic [7:0] shf_bits(input logic [1:0] sz);
    return 8'd8 << sz;
  endfunction
  function automatic logic [SHF_MAXW-1:0] shf_mask(input logic [1:0] sz);
    return {SHF_MAXW{1'b1}} >> (8'(SHF_MAXW) - shf_bits(sz));
  endfunction
endpackage

// File: rtl/shf_bytestage.sv
// shf_bytestage: coarse shift/rotate by whole bytes within the operand size, plus the
// bit that would be the carry-out if no fine (bit) shift follows.
module shf_bytestage
  import shf_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  shf_op_e          op_i,
  input  logic [7:0]       bits_i,
  input  logic [WIDTH-1:0] mask_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [3:0]       cb_i,
  output logic [WIDTH-1:0] y_o,
  output logic             cc_o
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic [7:0]       sh;
  logic [WIDTH-1:0] shl, shr, fill;
  logic             sign;
  always_comb begin
    sh   = {1'b0, cb_i, 3'b000};
    shl  = (x_i << sh) & mask_i;
    shr  = x_i >> sh;
    sign = |(x_i & ~(mask_i >> 1));
    fill = sign ? mask_i & ~(mask_i >> sh) : '0;
    y_o  = op_i == SHF_OP_SHL ? shl :
           op_i == SHF_OP_SHR ? shr :
           op_i == SHF_OP_SAR ? (shr | fill) :
           op_i == SHF_OP_ROL ? ((shl | (x_i >> (bits_i - sh))) & mask_i) :
                                ((shr | (x_i << (bits_i - sh))) & mask_i);
    cc_o = sh == 8'd0 ? 1'b0 :
           op_i == SHF_OP_SHL ? |(x_i & (ONE << (bits_i - sh))) :
                                |(x_i & (ONE << (sh - 8'd1)));
  end
endmodule

// File: rtl/pipe_shifter.sv
// pipe_shifter: two-stage shift/rotate pipeline (byte stage, then bit stage with cout/zf).
// Define PIPE_SHIFTER_ROTATE_EN to enable ROL/ROR; otherwise they pass through like reserved ops.
module pipe_shifter
  import shf_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [2:0]       op,
  input  logic [1:0]       sz,
  input  logic [WIDTH-1:0] val0,
  input  logic [SHW-1:0]   val1,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] valres,
  output logic             cout,
  output logic             zf
);
`ifdef PIPE_SHIFTER_ROTATE_EN
  localparam logic [2:0] OP_MAX = SHF_OP_ROR;
`else
  localparam logic [2:0] OP_MAX = SHF_OP_SAR;
`endif
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic             legal, cc, s1_adv;
  shf_op_e          op_n;
  logic [6:0]       cnt;
  logic [WIDTH-1:0] in_mask, x, y;
  logic             s1_vld_q, s1_cc_q, s1_any_q;
  shf_op_e          s1_op_q;
  logic [1:0]       s1_sz_q;
  logic [2:0]       s1_cl_q;
  logic [WIDTH-1:0] s1_data_q;
  logic             s2_vld_q, cout_q, zf_q;
  logic [WIDTH-1:0] valres_q;
  logic [7:0]       bits2, cl8;
  logic [WIDTH-1:0] mask2, shl, shr, fill, res_d;
  logic             sign, cout_d;
  // Reserved (or disabled) ops become a zero-count SHL: plain masked pass-through.
  always_comb begin
    legal   = op <= OP_MAX;
    op_n    = legal ? shf_op_e'(op) : SHF_OP_SHL;
    cnt     = legal ? 7'(val1) & 7'(shf_bits(sz) - 8'd1) : 7'd0;
    in_mask = WIDTH'(shf_mask(sz));
    x       = val0 & in_mask;
    s1_adv  = !s2_vld_q || out_rdy;
    in_rdy  = !s1_vld_q || s1_adv;
  end
  shf_bytestage #(.WIDTH(WIDTH)) u_bytestage (
    .op_i  (op_n),
    .bits_i(shf_bits(sz)),
    .mask_i(in_mask),
    .x_i   (x),
    .cb_i  (cnt[6:3]),
    .y_o   (y),
    .cc_o  (cc)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_op_q   <= SHF_OP_SHL;
      s1_sz_q   <= 2'd0;
      s1_cl_q   <= 3'd0;
      s1_any_q  <= 1'b0;
      s1_cc_q   <= 1'b0;
      s1_data_q <= '0;
    end else if (in_rdy) begin
      s1_vld_q <= in_vld;
      if (in_vld) begin
        s1_op_q   <= op_n;
        s1_sz_q   <= sz;
        s1_cl_q   <= cnt[2:0];
        s1_any_q  <= cnt != 7'd0;
        s1_cc_q   <= cc;
        s1_data_q <= y;
      end
    end
  end
  // Fine shift; with no fine count the carry is whatever the byte stage pushed out last.
  always_comb begin
    bits2  = shf_bits(s1_sz_q);
    mask2  = WIDTH'(shf_mask(s1_sz_q));
    cl8    = {5'd0, s1_cl_q};
    shl    = (s1_data_q << cl8) & mask2;
    shr    = s1_data_q >> cl8;
    sign   = |(s1_data_q & ~(mask2 >> 1));
    fill   = sign ? mask2 & ~(mask2 >> cl8) : '0;
    res_d  = s1_op_q == SHF_OP_SHL ? shl :
             s1_op_q == SHF_OP_SHR ? shr :
             s1_op_q == SHF_OP_SAR ? (shr | fill) :
             s1_op_q == SHF_OP_ROL ? ((shl | (s1_data_q >> (bits2 - cl8))) & mask2) :
                                     ((shr | (s1_data_q << (bits2 - cl8))) & mask2);
    cout_d = !s1_any_q ? 1'b0 :
             s1_op_q == SHF_OP_ROL ? res_d[0] :
             s1_op_q == SHF_OP_ROR ? |(res_d & (ONE << (bits2 - 8'd1))) :
             cl8 == 8'd0 ? s1_cc_q :
             s1_op_q == SHF_OP_SHL ? |(s1_data_q & (ONE << (bits2 - cl8))) :
                                     |(s1_data_q & (ONE << (cl8 - 8'd1)));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld_q <= 1'b0;
      valres_q <= '0;
      cout_q   <= 1'b0;
      zf_q     <= 1'b0;
    end else if (s1_adv) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        valres_q <= res_d;
        cout_q   <= cout_d;
        zf_q     <= res_d == '0;
      end
    end
  end
  assign out_vld = s2_vld_q;
  assign valres  = valres_q;
  assign cout    = cout_q;
  assign zf      = zf_q;
endmodule

// File: tb/tb_pipe_shifter.sv
// tb_pipe_shifter: randomized scoreboard bench for pipe_shifter against a bit-level reference model.
module tb_pipe_shifter;
`ifdef PIPE_SHIFTER_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif
  logic        clk, rst, in_vld, in_rdy, out_vld, out_rdy, cout, zf;
  logic [2:0]  op;
  logic [1:0]  sz;
  logic [63:0] val0, valres;
  logic [5:0]  val1;
  typedef struct {
    logic [63:0] r;
    logic        c;
    logic        z;
  } exp_t;
  exp_t        q[$];
  exp_t        e;
  int          n_chk = 0, n_fail = 0, n_pop = 0;
  logic        held = 1'b0, held_c, held_z;
  logic [63:0] held_r;

  pipe_shifter #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .op(op), .sz(sz),
    .val0(val0), .val1(val1), .out_vld(out_vld), .out_rdy(out_rdy),
    .valres(valres), .cout(cout), .zf(zf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: each result bit is picked directly from the operand by index arithmetic.
  function automatic void model(input logic [2:0] o, input logic [1:0] s_, input logic [63:0] v,
                                input logic [5:0] n, output logic [63:0] r, output logic co,
                                output logic z);
    int s = 8 << s_;
    int c = int'(n) % s;
    int k = int'(o);
    if (k > (ROT ? 4 : 2)) begin
      k = 0;
      c = 0;
    end
    r = '0;
    for (int i = 0; i < s; i++)
      case (k)
        0: r[i] = (i >= c) ? v[i-c] : 1'b0;
        1: r[i] = (i + c < s) ? v[i+c] : 1'b0;
        2: r[i] = (i + c < s) ? v[i+c] : v[s-1];
        3: r[i] = v[(i - c + s) % s];
        default: r[i] = v[(i + c) % s];
      endcase
    co = (c == 0) ? 1'b0 : (k == 0) ? v[s-c] : (k <= 2) ? v[c-1] : (k == 3) ? r[0] : r[s-1];
    z  = r == 64'd0;
  endfunction

  always @(negedge clk) begin
    if (rst) held = 1'b0;
    else begin
      if (held && out_vld) begin
        chk("stall_valres", valres, held_r);
        chk("stall_cout", cout, held_c);
        chk("stall_zf", zf, held_z);
      end
      if (in_vld && in_rdy) begin
        model(op, sz, val0, val1, e.r, e.c, e.z);
        q.push_back(e);
      end
      if (out_vld && out_rdy) begin
        if (q.size() == 0) chk("unexpected_out", out_vld, 0);
        else begin
          e = q.pop_front();
          n_pop++;
          chk("sb_valres", valres, e.r);
          chk("sb_cout", cout, e.c);
          chk("sb_zf", zf, e.z);
        end
      end
      held   = out_vld && !out_rdy;
      held_r = valres;
      held_c = cout;
      held_z = zf;
    end
  end

  task automatic direct(input string nm, input logic [2:0] o, input logic [1:0] s_,
                        input logic [63:0] v, input logic [5:0] n, input logic [63:0] er,
                        input logic ec);
    out_rdy = 1'b1; op = o; sz = s_; val0 = v; val1 = n; in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    chk({nm, "_lat1"}, out_vld, 0);
    @(posedge clk); #1;
    chk({nm, "_lat2"}, out_vld, 1);
    chk({nm, "_res"}, valres, er);
    chk({nm, "_cout"}, cout, ec);
    chk({nm, "_zf"}, zf, er == 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic rnd_op();
    op = 3'($urandom_range(0, 7)); sz = 2'($urandom_range(0, 3));
    val0 = {$urandom, $urandom}; val1 = 6'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    int   idx, pop0;
    rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0; op = '0; sz = '0; val0 = '0; val1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_vld", out_vld, 0);
    chk("rst_valres", valres, 0);
    chk("rst_cout", cout, 0);
    chk("rst_zf", zf, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_rdy", in_rdy, 1);
    direct("shl64", 3'd0, 2'd3, 64'h8000_0000_0000_0001, 6'd1, 64'h2, 1'b1);
    direct("sar32", 3'd2, 2'd2, 64'h0000_0000_8000_0000, 6'd35, 64'hF000_0000, 1'b0);
    direct("ror8", 3'd4, 2'd0, 64'h01, 6'd1, ROT ? 64'h80 : 64'h01, ROT);
    direct("shr16_cnt0", 3'd1, 2'd1, 64'hFFFF_1234, 6'd16, 64'h1234, 1'b0);
    direct("rsvd_op", 3'd7, 2'd0, 64'h1A5, 6'd3, 64'hA5, 1'b0);
    // Eight back-to-back ops with the consumer stalled for cycles 3..5.
    idx = 0; pop0 = n_pop;
    for (int cyc = 0; cyc < 40 && (idx < 8 || q.size() > 0); cyc++) begin
      out_rdy = !(cyc >= 3 && cyc <= 5);
      in_vld  = idx < 8;
      if (idx < 8) rnd_op();
      @(negedge clk);
      if (cyc == 0) chk("b2b_in_rdy_empty", in_rdy, 1);
      if (cyc >= 3 && cyc <= 5) chk("b2b_in_rdy_full", in_rdy, 0);
      acc = in_vld && in_rdy;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_vld = 1'b0;
    chk("b2b_count", n_pop - pop0, 8);
    // Random traffic with random back-pressure.
    for (int cyc = 0; cyc < 600; cyc++) begin
      out_rdy = $urandom_range(0, 3) != 0;
      in_vld  = $urandom_range(0, 4) != 0;
      rnd_op();
      @(posedge clk); #1;
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 0);
    // Reset with two ops in flight.
    out_rdy = 1'b0; rnd_op(); in_vld = 1'b1;
    @(posedge clk); #1;
    rnd_op();
    @(posedge clk); #1;
    in_vld = 1'b0;
    chk("inflight_out_vld", out_vld, 1);
    rst = 1'b1;
    q.delete();
    #1;
    chk("midrst_out_vld", out_vld, 0);
    chk("midrst_valres", valres, 0);
    @(posedge clk); #1;
    rst = 1'b0; out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("post_rst_quiet", out_vld, 0);
    end
    direct("after_rst", 3'd1, 2'd2, 64'h0000_0000_8000_0010, 6'd5, 64'h0400_0000, 1'b1);
    chk("final_queue", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
